// File: rtl/ps2_scancode_decoder.sv
// PS/2 frame decoder. Validates 11-bit frames, folds E0/F0 prefixes into key
// events and queues them in a small FIFO. Runs on the system clock.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [10:0] iKey_Data_In,
    input  logic        iData_Ready,
    output logic        oData_Received,
    output logic [9:0]  oEvent_Data,
    output logic        oEvent_Valid,
    input  logic        iEvent_Read,
    output logic        oOverflow,
    output logic [7:0]  oError_Count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACK
    } state_t;

    state_t state_q, state_d;

    logic             rdy_meta, rdy_s;
    logic [10:0]      frame_q;
    logic             ext_q, brk_q;
    logic [7:0]       err_q;
    logic             ovf_q;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic       capture, push_req, set_ext, set_brk, clr_flags, err_inc;
    logic       frame_ok, fifo_full, fifo_empty, pop, push, drop;
    logic [7:0] code;

    assign code       = frame_q[8:1];
    assign frame_ok   = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = iEvent_Read & ~fifo_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            rdy_meta <= iData_Ready;
            rdy_s    <= rdy_meta;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        push_req  = 1'b0;
        set_ext   = 1'b0;
        set_brk   = 1'b0;
        clr_flags = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_s) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = ACK;
                if (!frame_ok) begin
                    err_inc   = 1'b1;
                    clr_flags = 1'b1;
                end else if (code == 8'hE0) begin
                    set_ext = 1'b1;
                end else if (code == 8'hF0) begin
                    set_brk = 1'b1;
                end else begin
                    push_req  = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            ACK: begin
                if (!rdy_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_q <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (capture) frame_q <= iKey_Data_In;
            if (clr_flags) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else begin
                if (set_ext) ext_q <= 1'b1;
                if (set_brk) brk_q <= 1'b1;
            end
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= {brk_q, ext_q, code};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    assign oData_Received = (state_q == ACK);
    assign oEvent_Valid   = ~fifo_empty;
    assign oEvent_Data    = fifo_empty ? '0 : mem[rd_ptr];
    assign oOverflow      = ovf_q;
    assign oError_Count   = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed steps plus random frames checked
// against a queue-based model of the event stream.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] iKey_Data_In = '0;
    logic        iData_Ready = 1'b0;
    logic        iEvent_Read = 1'b0;
    logic        oData_Received;
    logic [9:0]  oEvent_Data;
    logic        oEvent_Valid;
    logic        oOverflow;
    logic [7:0]  oError_Count;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iKey_Data_In   (iKey_Data_In),
        .iData_Ready    (iData_Ready),
        .oData_Received (oData_Received),
        .oEvent_Data    (oEvent_Data),
        .oEvent_Valid   (oEvent_Valid),
        .iEvent_Read    (iEvent_Read),
        .oOverflow      (oOverflow),
        .oError_Count   (oError_Count)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    logic [9:0] mq[$];
    int         m_err;
    bit         m_ovf, m_ext, m_brk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] code, input int bad);
        logic [10:0] f;
        f = {1'b1, ~(^code), code, 1'b0};
        case (bad)
            1: f[9]  = ~f[9];
            2: f[10] = 1'b0;
            3: f[0]  = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_err = 0;
        m_ovf = 0;
        m_ext = 0;
        m_brk = 0;
    endfunction

    function automatic void model_frame(input logic [10:0] f, input bit pop_same);
        logic [7:0] c;
        bit ok;
        c  = f[8:1];
        ok = (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
        if (pop_same && mq.size() > 0) void'(mq.pop_front());
        if (!ok) begin
            if (m_err < 255) m_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, c});
            else m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        logic [9:0] head;
        head = (mq.size() > 0) ? mq[0] : 10'h000;
        chk({tag, ".valid"}, 32'(oEvent_Valid), 32'(mq.size() > 0));
        chk({tag, ".data"},  32'(oEvent_Data),  32'(head));
        chk({tag, ".err"},   32'(oError_Count), 32'(m_err));
        chk({tag, ".ovf"},   32'(oOverflow),    32'(m_ovf));
    endtask

    task automatic wait_ack_fall(input string tag);
        int n;
        n = 0;
        while (oData_Received === 1'b1 && n < 8) begin
            @(posedge Clock); #1;
            n++;
        end
        chk({tag, ".ack_fall"}, 32'(n >= 2 && n <= 3), 32'd1);
    endtask

    task automatic send(input logic [10:0] f, input bit pop_same, input string tag);
        @(negedge Clock);
        iKey_Data_In = f;
        iData_Ready  = 1'b1;
        repeat (3) @(posedge Clock);
        #1 chk({tag, ".ack_early"}, 32'(oData_Received), 32'd0);
        if (pop_same) begin
            @(negedge Clock);
            iEvent_Read = 1'b1;
        end
        @(posedge Clock);
        model_frame(f, pop_same);
        #1 chk({tag, ".ack"}, 32'(oData_Received), 32'd1);
        check_model(tag);
        @(negedge Clock);
        iEvent_Read = 1'b0;
        iData_Ready = 1'b0;
        wait_ack_fall(tag);
    endtask

    task automatic pop(input string tag);
        @(negedge Clock);
        iEvent_Read = 1'b1;
        @(posedge Clock);
        if (mq.size() > 0) void'(mq.pop_front());
        #1 check_model(tag);
        @(negedge Clock);
        iEvent_Read = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] c;
        int bad;

        // Reset state
        model_reset();
        repeat (2) @(posedge Clock);
        #1 chk("reset.ack", 32'(oData_Received), 32'd0);
        check_model("reset");
        @(negedge Clock);
        Reset = 1'b0;

        // Single make code
        send(mk(8'h1C, 0), 0, "make1c");
        chk("make1c.value", 32'(oEvent_Data), 32'h01C);
        pop("pop1c");

        // Extended break, then plain make proves flags cleared
        send(mk(8'hE0, 0), 0, "e0");
        send(mk(8'hF0, 0), 0, "f0");
        send(mk(8'h75, 0), 0, "ext_brk75");
        chk("ext_brk75.value", 32'(oEvent_Data), 32'h375);
        pop("pop375");
        send(mk(8'h75, 0), 0, "plain75");
        chk("plain75.value", 32'(oEvent_Data), 32'h075);
        pop("pop075");

        // Prefix order F0 E0
        send(mk(8'hF0, 0), 0, "f0b");
        send(mk(8'hE0, 0), 0, "e0b");
        send(mk(8'h6B, 0), 0, "brk_ext6b");
        chk("brk_ext6b.value", 32'(oEvent_Data), 32'h36B);
        pop("pop36b");

        // Framing errors; an error clears a pending break prefix
        send(mk(8'h1C, 1), 0, "badpar");
        send(mk(8'h1C, 2), 0, "badstop");
        send(mk(8'h1C, 3), 0, "badstart");
        chk("errs.count", 32'(oError_Count), 32'd3);
        send(mk(8'hF0, 0), 0, "f0c");
        send(mk(8'h00, 1), 0, "badc");
        send(mk(8'h1C, 0), 0, "after_err");
        chk("after_err.value", 32'(oEvent_Data), 32'h01C);
        pop("pop_after_err");

        // Fill FIFO, push+pop while full, then overflow
        send(mk(8'h15, 0), 0, "fill0");
        send(mk(8'h1D, 0), 0, "fill1");
        send(mk(8'h24, 0), 0, "fill2");
        send(mk(8'h2D, 0), 0, "fill3");
        send(mk(8'h2C, 0), 1, "pushpop_full");
        chk("pushpop_full.ovf", 32'(oOverflow), 32'd0);
        send(mk(8'h35, 0), 0, "overflow");
        chk("overflow.ovf", 32'(oOverflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop("drain");
        chk("drain.empty", 32'(oEvent_Valid), 32'd0);

        // Reset while in ACK with two events queued; held E0 is re-decoded
        send(mk(8'h16, 0), 0, "q0");
        send(mk(8'h1E, 0), 0, "q1");
        @(negedge Clock);
        iKey_Data_In = mk(8'hE0, 0);
        iData_Ready  = 1'b1;
        repeat (4) @(posedge Clock);
        model_frame(mk(8'hE0, 0), 0);
        #1 chk("rst_ack.ack", 32'(oData_Received), 32'd1);
        chk("rst_ack.count", 32'(mq.size()), 32'd2);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        model_reset();
        #1 chk("rst_ack.ack_cleared", 32'(oData_Received), 32'd0);
        check_model("rst_ack");
        @(negedge Clock);
        Reset = 1'b0;
        n = 0;
        while (oData_Received !== 1'b1 && n < 10) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("redecode.ack_seen", 32'(oData_Received), 32'd1);
        model_frame(mk(8'hE0, 0), 0);
        check_model("redecode");
        @(negedge Clock);
        iData_Ready = 1'b0;
        wait_ack_fall("redecode");
        send(mk(8'h75, 0), 0, "redecode75");
        chk("redecode75.value", 32'(oEvent_Data), 32'h175);
        pop("pop175");

        // Random frames with random prefixes, errors and reads
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       c = 8'hE0;
                1:       c = 8'hF0;
                default: c = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(mk(c, bad), ($urandom_range(0, 3) == 0), "rand");
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) pop("rand_pop");
        end
        while (mq.size() > 0) pop("final_drain");
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
